// File: rtl/rv_pkg.sv
// Shared register-file writeback definitions: widths, register count,
// the hard-wired zero register, and the {rd, wd} writeback request record.
package rv_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 2 ** REG_AW;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wd;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate occupancy counter.
// Push is ignored when full and pop is ignored when empty; storage is not
// reset, only the pointers are.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  logic    i_pop,
    input  wb_req_t i_din,
    output wb_req_t o_dout,
    output logic    o_full,
    output logic    o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    wb_req_t     r_mem [DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer advance; wrap is implicit in the power-of-two pointer width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Entry storage, written at the tail slot on an accepted push.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter. Source A (single-cycle writeback) always
// wins; source B (long-latency results, valid/ready) is queued in wb_fifo and
// drained whenever A is idle. A busy scoreboard tracks registers with pending
// B results so decode can stall, and waw_err latches write-after-write hazards.
// Build option WB_BYPASS_EN: when A is idle and the queue is empty, an accepted
// B result commits in its acceptance cycle instead of being queued.
module wb_arbiter
    import rv_pkg::*;
#(
    parameter int XLEN   = rv_pkg::XLEN,
    parameter int REG_AW = rv_pkg::REG_AW,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic [REG_AW-1:0] a_rd,
    input  logic [XLEN-1:0]   a_wd,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_rd,
    input  logic [XLEN-1:0]   b_wd,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              busy_rs1,
    output logic              busy_rs2,
    output logic              regwrite,
    output logic [REG_AW-1:0] wr,
    output logic [XLEN-1:0]   wd,
    output logic              waw_err
);
    localparam int NR = 2 ** REG_AW;

    logic              w_a_act;
    logic              w_b_acc;
    logic              w_push;
    logic              w_pop;
    logic              w_byp;
    logic              w_full;
    logic              w_empty;
    logic              w_clr;
    logic [REG_AW-1:0] w_clr_rd;
    logic              w_iss_set;
    wb_req_t           w_push_req;
    wb_req_t           w_head;

    logic [NR-1:0]     r_busy;
    logic              r_waw_err;

    assign w_a_act    = a_we && (a_rd != ZERO_REG);
    // A head popping in the same cycle does not make room: ready is just !full.
    assign b_ready    = !rst && !w_full;
    assign w_b_acc    = b_valid && b_ready;
    assign w_push     = w_b_acc && (b_rd != ZERO_REG) && !w_byp;
    assign w_iss_set  = iss_valid && (iss_rd != ZERO_REG);
    assign w_push_req = '{rd: b_rd, wd: b_wd};

    assign busy_rs1   = !rst && r_busy[rs1] && (rs1 != ZERO_REG);
    assign busy_rs2   = !rst && r_busy[rs2] && (rs2 != ZERO_REG);
    assign waw_err    = r_waw_err;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_push_req),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Commit mux: A first, then the queue head, then (optionally) a bypassed B.
    always_comb begin
        regwrite = 1'b0;
        wr       = a_rd;
        wd       = a_wd;
        w_pop    = 1'b0;
        w_byp    = 1'b0;
        w_clr    = 1'b0;
        w_clr_rd = w_head.rd;
        if (!rst) begin
            if (w_a_act) begin
                regwrite = 1'b1;
            end else if (!w_empty) begin
                regwrite = 1'b1;
                wr       = w_head.rd;
                wd       = w_head.wd;
                w_pop    = 1'b1;
                w_clr    = 1'b1;
            end
`ifdef WB_BYPASS_EN
            else if (w_b_acc && (b_rd != ZERO_REG)) begin
                regwrite = 1'b1;
                wr       = b_rd;
                wd       = b_wd;
                w_byp    = 1'b1;
                w_clr    = 1'b1;
                w_clr_rd = b_rd;
            end
`endif
        end
    end

    // Busy scoreboard; the set is written last so it wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (w_clr)     r_busy[w_clr_rd] <= 1'b0;
            if (w_iss_set) r_busy[iss_rd]   <= 1'b1;
        end
    end

    // Sticky WAW flag: A overwriting a pending register, or re-issuing to one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_waw_err <= 1'b0;
        end else if ((w_a_act && r_busy[a_rd]) || (w_iss_set && r_busy[iss_rd])) begin
            r_waw_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter. Stimulus pushes each expected commit
// {cycle, wr, wd} into a queue; an independent monitor checks every regwrite
// against the queue head and flags missed or unexpected commits.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_we;
    logic [4:0]  a_rd;
    logic [31:0] a_wd;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_wd;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        regwrite;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        waw_err;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] wd;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wb_arbiter #(.XLEN(32), .REG_AW(5), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_we      (a_we),
        .a_rd      (a_rd),
        .a_wd      (a_wd),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_rd      (b_rd),
        .b_wd      (b_wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2),
        .regwrite  (regwrite),
        .wr        (wr),
        .wd        (wd),
        .waw_err   (waw_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic expect_wb(input int c, input logic [4:0] rd, input logic [31:0] d);
        exp_t e;
        e.cyc = c;
        e.rd  = rd;
        e.wd  = d;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Monitor: compare each commit with the scoreboard head, report misses.
    always @(negedge clk) begin
        exp_t e;
        if (regwrite === 1'b1) begin
            n_total++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_commit: got wr=%0d wd=%0h at cycle %0d, required no commit",
                         wr, wd, cyc);
            end else begin
                e = q.pop_front();
                if (e.cyc == cyc && e.rd === wr && e.wd === wd)
                    n_pass++;
                else
                    $display("FAIL commit: got cycle %0d wr=%0d wd=%0h, required cycle %0d wr=%0d wd=%0h",
                             cyc, wr, wd, e.cyc, e.rd, e.wd);
            end
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_total++;
            $display("FAIL missed_commit: got no commit, required cycle %0d wr=%0d wd=%0h",
                     e.cyc, e.rd, e.wd);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; a_we = 1'b0; a_rd = '0; a_wd = '0;
        b_valid = 1'b1; b_rd = 5'd3; b_wd = 32'h33;
        iss_valid = 1'b0; iss_rd = '0; rs1 = 5'd3; rs2 = '0;

        // reset held two cycles with B offering a result
        tick(); settle();
        chk("rst_regwrite", regwrite, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_busy_rs1", busy_rs1, 0);
        tick(); settle();
        chk("rst_regwrite2", regwrite, 0);
        chk("rst_b_ready2", b_ready, 0);
        tick(); rst = 1'b0; b_valid = 1'b0; settle();
        chk("rel_b_ready", b_ready, 1);
        chk("rel_waw_err", waw_err, 0);

        // A only, then A to x0
        tick(); a_we = 1'b1; a_rd = 5'd5; a_wd = 32'hDEADBEEF;
        expect_wb(cyc, 5'd5, 32'hDEADBEEF);
        settle();
        chk("a_regwrite", regwrite, 1);
        tick(); a_rd = 5'd0; settle();
        chk("x0_regwrite", regwrite, 0);

        // conflict: x7 issued, B result for x7 queued behind three A writes
        tick(); a_we = 1'b0; iss_valid = 1'b1; iss_rd = 5'd7; settle();
        tick(); iss_valid = 1'b0; rs1 = 5'd7;
        b_valid = 1'b1; b_rd = 5'd7; b_wd = 32'h11;
        a_we = 1'b1; a_rd = 5'd3; a_wd = 32'h30;
        expect_wb(cyc, 5'd3, 32'h30);
        settle();
        chk("cf_busy0", busy_rs1, 1);
        chk("cf_b_ready", b_ready, 1);
        tick(); b_valid = 1'b0; a_wd = 32'h31;
        expect_wb(cyc, 5'd3, 32'h31);
        settle();
        chk("cf_busy1", busy_rs1, 1);
        tick(); a_wd = 32'h32;
        expect_wb(cyc, 5'd3, 32'h32);
        settle();
        chk("cf_busy2", busy_rs1, 1);
        tick(); a_we = 1'b0;
        expect_wb(cyc, 5'd7, 32'h11);
        settle();
        chk("cf_busy_commit", busy_rs1, 1);
        tick(); settle();
        chk("cf_busy_cleared", busy_rs1, 0);
        chk("cf_waw_err", waw_err, 0);

        // full: four B results queued under continuous A traffic
        for (int i = 1; i <= 4; i++) begin
            tick(); a_we = 1'b1; a_rd = 5'd10; a_wd = 32'hA0 + i;
            b_valid = 1'b1; b_rd = 5'(i); b_wd = 32'h100 + i;
            expect_wb(cyc, 5'd10, 32'hA0 + i);
            settle();
            chk($sformatf("full_ready_%0d", i), b_ready, 1);
        end
        tick(); a_wd = 32'hA5; b_rd = 5'd5; b_wd = 32'h105;
        expect_wb(cyc, 5'd10, 32'hA5);
        settle();
        chk("full_ready_5", b_ready, 0);
        tick(); a_we = 1'b0; b_valid = 1'b0;
        for (int k = 0; k < 4; k++) expect_wb(cyc + k, 5'(k + 1), 32'h101 + k);
        settle();
        chk("full_pop_ready", b_ready, 0);
        tick(); settle();
        chk("full_after_pop", b_ready, 1);
        tick(); tick(); tick();

        // hazard: A writes a register with a pending B result
        tick(); iss_valid = 1'b1; iss_rd = 5'd9; rs2 = 5'd9; settle();
        chk("hz_waw_before", waw_err, 0);
        tick(); iss_valid = 1'b0; a_we = 1'b1; a_rd = 5'd9; a_wd = 32'h99;
        expect_wb(cyc, 5'd9, 32'h99);
        settle();
        chk("hz_busy_rs2", busy_rs2, 1);
        chk("hz_waw_same", waw_err, 0);
        tick(); a_we = 1'b0; settle();
        chk("hz_waw_set", waw_err, 1);
        tick(); tick(); settle();
        chk("hz_waw_sticky", waw_err, 1);
        tick(); rst = 1'b1; settle();
        chk("hz_rst_busy", busy_rs2, 0);
        tick(); rst = 1'b0; settle();
        chk("hz_waw_cleared", waw_err, 0);
        chk("hz_busy_cleared", busy_rs2, 0);

        // hazard: re-issue to a register already busy
        tick(); iss_valid = 1'b1; iss_rd = 5'd12;
        tick(); settle();
        tick(); iss_valid = 1'b0; settle();
        chk("reiss_waw", waw_err, 1);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;

        // reset with a queued B result discards it
        tick(); a_we = 1'b1; a_rd = 5'd4; a_wd = 32'h44;
        b_valid = 1'b1; b_rd = 5'd8; b_wd = 32'h88;
        expect_wb(cyc, 5'd4, 32'h44);
        tick(); rst = 1'b1; a_we = 1'b0; b_valid = 1'b0; settle();
        chk("midrst_regwrite", regwrite, 0);
        tick(); rst = 1'b0; settle();
        chk("midrst_discard", regwrite, 0);

        // B result to x0 is accepted and dropped
        tick(); b_valid = 1'b1; b_rd = 5'd0; b_wd = 32'h55; settle();
        chk("bx0_ready", b_ready, 1);
        tick(); b_valid = 1'b0; settle();
        chk("bx0_regwrite", regwrite, 0);

        // B with A idle and queue empty: latency 0 with bypass, else 1
        tick(); b_valid = 1'b1; b_rd = 5'd6; b_wd = 32'h22;
`ifdef WB_BYPASS_EN
        expect_wb(cyc, 5'd6, 32'h22);
`else
        expect_wb(cyc + 1, 5'd6, 32'h22);
`endif
        tick(); b_valid = 1'b0;
        tick(); tick(); settle();

        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Drives the register file's single write port (regwrite/wr/wd) from two sources.
- Source A is the single-cycle datapath's writeback and always has priority.
- Source B is a long-latency unit (mul/div or memory) using a valid/ready handshake, buffered in a small FIFO.
- Holds a 32-entry busy scoreboard so decode can stall on registers with pending B results.

Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register address width (2**REG_AW registers).
- DEPTH, 4, B-result FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset, sampled on posedge clk.
- a_we  in  1  datapath writeback enable.
- a_rd  in  REG_AW  datapath destination register.
- a_wd  in  XLEN  datapath write data.
- b_valid  in  1  long-op result valid.
- b_ready  out  1  arbiter can accept B result.
- b_rd  in  REG_AW  long-op destination register.
- b_wd  in  XLEN  long-op result data.
- iss_valid  in  1  long op issued this cycle (marks destination busy).
- iss_rd  in  REG_AW  destination of issued long op.
- rs1  in  REG_AW  decode read address 1.
- rs2  in  REG_AW  decode read address 2.
- busy_rs1  out  1  rs1 has a pending B write.
- busy_rs2  out  1  rs2 has a pending B write.
- regwrite  out  1  register file write enable.
- wr  out  REG_AW  register file write address.
- wd  out  XLEN  register file write data.
- waw_err  out  1  sticky write-after-write violation flag.

Behaviour:
- Reset: FIFO empty, busy[] cleared, waw_err=0. While rst=1: regwrite=0, b_ready=0, busy_rs1=busy_rs2=0. wr/wd are don't-care when regwrite=0.
- A active = a_we & (a_rd!=0). Writes to x0 are dropped and never reach regwrite.
- Commit mux (combinational, same cycle):
  - A active: regwrite=1, wr=a_rd, wd=a_wd. A has zero latency.
  - Else FIFO non-empty: commit FIFO head, pop at posedge.
  - Else regwrite=0.
- B handshake: transfer when b_valid & b_ready. b_ready = !full; a transfer is refused in the cycle the FIFO is full, even if the head pops that cycle. Accepted entries go to the FIFO tail. An accepted entry with b_rd==0 is discarded (not enqueued).
- Min B latency: accepted in cycle N, earliest commit in cycle N+1. Commit order equals acceptance order.
- Simultaneous push and pop on a non-full FIFO: occupancy unchanged. Pointers wrap modulo DEPTH.
- Scoreboard, per register r:
  - Set when iss_valid & iss_rd==r & r!=0.
  - Cleared when a FIFO head with wr==r commits.
  - Set and clear of the same r in the same cycle: set wins.
- busy_rsN = busy[rsN] & (rsN!=0), combinational.
- waw_err set (sticky until rst) when either:
  - A active and busy[a_rd]; the A write still proceeds;
  - iss_valid to an already-busy register.
- Reset mid-operation discards FIFO contents and the scoreboard; no commit occurs in the reset cycle.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when A is inactive and the FIFO is empty, an accepted B result commits in the same cycle (regwrite=1, wr=b_rd, wd=b_wd). It is not enqueued and its busy bit is cleared that cycle. Zero latency.
- Undefined: every B result goes through the FIFO; minimum latency is 1 cycle.

Decomposition:
- Shared package rv_pkg: XLEN, REG_AW, NREGS, ZERO_REG constant, and a wb_req typedef {rd, wd}.
- Natural sub-module: wb_fifo (synchronous FIFO, DEPTH x wb_req, push/pop/full/empty).
- Scoreboard and commit mux stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with b_valid=1 -> regwrite=0, b_ready=0, busy_rs1=0; after release b_ready=1, waw_err=0.
- A only: a_we=1, a_rd=5, a_wd=0xDEADBEEF -> same cycle regwrite=1, wr=5, wd=0xDEADBEEF. Repeat with a_rd=0 -> regwrite=0.
- Conflict:
  - Setup: iss_rd=7 issued; then B (rd=7, wd=0x11) accepted while A writes x3 for 3 consecutive cycles.
  - Required: busy_rs1(rs1=7)=1 throughout; x3 commits first; x7/0x11 commits the first cycle A is idle; busy clears the next cycle.
- Full:
  - Setup: A active continuously; push DEPTH=4 B results (rd=1..4).
  - Required: b_ready=0 on the 5th; after A goes idle, commits occur in order 1,2,3,4 on consecutive cycles.
- Hazard: issue iss_rd=9, then A writes x9 -> write occurs, waw_err=1 and stays 1 until rst.
- Bypass: WB_BYPASS_EN, FIFO empty, A idle, B rd=6 wd=0x22 -> commit in the acceptance cycle. Without the macro -> commit exactly 1 cycle later.
